// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Shares the single-port DataMemory between the CPU load/store port (port 0)
// and the DMA/program-loader port (port 1). It handles one transaction at a
// time. The winner's address, data and direction are latched. DataMemory is
// then driven for exactly one cycle, read data is captured into the owner's
// RData, and a one-cycle Ack goes back to the owner.
//
// Ports
//   Clock, Reset                       system clock, async active-high reset
//   Req0/Wr0/Addr0/WData0              port 0 request, held until Ack0
//   Ack0/RData0                        port 0 completion pulse, read data
//   Req1/Wr1/Addr1/WData1/Ack1/RData1  same for port 1
//   Adresa/WriteData/MemWrite/MemRead  DataMemory drive
//   ReadData                           DataMemory combinational read data
//   Busy                               high in ACCESS and DONE
//   Grant                              one-hot owner (bit 0 = port 0), 00 when idle
//
// State   | meaning
// IDLE    | waiting for a request; the winner is latched on the edge leaving it
// ACCESS  | DataMemory driven from the latched request for one cycle
// DONE    | Ack to the owner; Grant still valid

module data_memory_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Wr0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Ack0,
    output logic [DATA_W-1:0] RData0,
    input  logic              Req1,
    input  logic              Wr1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData1,
    output logic [ADDR_W-1:0] Adresa,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData,
    output logic              Busy,
    output logic [1:0]        Grant
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic [1:0]        grant_q;
    logic              last_grant;   // 0: port 0 served last, 1: port 1
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              take;
    logic              win1;

    // On a tie, round-robin hands the slot to the port not served last.
    always_comb begin
        win1 = 1'b0;
        if (Req0 && Req1) begin
            win1 = FIXED_PRIORITY ? 1'b0 : ~last_grant;
        end else begin
            win1 = Req1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The memory strobes are decoded from the state register, so an async
    // reset mid-ACCESS drops MemWrite at once and the write never commits.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Ack0      = 1'b0;
        Ack1      = 1'b0;
        Busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (Req0 || Req1) begin
                    take      = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                Busy      = 1'b1;
                MemWrite  = wr_q;
                MemRead   = ~wr_q;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                Busy      = 1'b1;
                Ack0      = grant_q[0];
                Ack1      = grant_q[1];
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            grant_q    <= 2'b00;
            last_grant <= 1'b1;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            if (take) begin
                addr_q     <= win1 ? Addr1 : Addr0;
                wdata_q    <= win1 ? WData1 : WData0;
                wr_q       <= win1 ? Wr1 : Wr0;
                grant_q    <= win1 ? 2'b10 : 2'b01;
                last_grant <= win1;
            end
            if (state == ST_ACCESS && !wr_q) begin
                if (grant_q[0]) begin
                    rdata0_q <= ReadData;
                end
                if (grant_q[1]) begin
                    rdata1_q <= ReadData;
                end
            end
            if (state == ST_DONE) begin
                grant_q <= 2'b00;
            end
        end
    end

    assign Adresa    = addr_q;
    assign WriteData = wdata_q;
    assign Grant     = grant_q;
    assign RData0    = rdata0_q;
    assign RData1    = rdata1_q;

endmodule
